apb_uart_fifo: RTL and testbench

//  APB3 UART peripheral with parametrised TX/RX FIFOs, 16x-oversampled baud generator, optional parity,

---
 rtl/apb_uart_fifo.sv | 330 +++++++++++++++++++++++++++++++++
 tb/tb_apb_uart_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : apb_uart_fifo (with helper apb_uart_fifo_buf)
//  Purpose  : APB3 UART with TX/RX byte FIFOs, a 16x-oversampled baud tick,
//             optional odd/even parity, sticky error flags and a level IRQ.
//  Ports    : PCLK/PRESETN     clock, asynchronous active-low reset
//             PADDR..PSLVERR   APB3 slave; PRDATA registered at setup phase
//             RX / TX          serial input (asynchronous) / serial output
//             IRQ              level interrupt, active-high
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  apb_uart_fifo_buf: byte FIFO with occupancy count. Push on full is accepted
//  only when a pop happens in the same cycle; pop on empty is ignored.
// ----------------------------------------------------------------------------
module apb_uart_fifo_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        i_push,
    input  logic [7:0]  i_data,
    input  logic        i_pop,
    output logic [7:0]  o_data,
    output logic [AW:0] o_count,
    output logic        o_empty,
    output logic        o_full
);
    localparam logic [AW:0] c_FULL = DEPTH[AW:0];

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == c_FULL);
    assign o_count = count_q;
    assign o_data  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = i_push & (~o_full | i_pop);
        do_pop   = i_pop & ~o_empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + 1'b1;
        else if (do_pop && !do_push)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (do_push)
            mem_q[wr_ptr_q] <= i_data;
    end
endmodule

module apb_uart_fifo #(
    parameter int FIFO_DEPTH  = 16,
    parameter int BAUD_W      = 13,
    parameter int SYNC_STAGES = 2
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic [4:0]  PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [15:0] PWDATA,
    output logic [15:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        RX,
    output logic        TX,
    output logic        IRQ
);
    localparam int c_AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } uart_state_t;

    // Registers
    logic [BAUD_W-1:0]      baud_q, baud_d, baud_cnt_q, baud_cnt_d;
    logic [3:0]             ctrl_q, ctrl_d;
    logic [2:0]             ier_q, ier_d;
    logic [c_AW:0]          rxthr_q, rxthr_d;
    logic [2:0]             err_q, err_d;      // {frm_err, par_err, rx_ovf}
    logic [15:0]            prdata_q, prdata_d;
    logic [SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
    logic                   rx_prev_q;
    // TX engine
    uart_state_t            tx_state_q, tx_state_d;
    logic [3:0]             tx_tick_q, tx_tick_d;
    logic [2:0]             tx_bit_q, tx_bit_d;
    logic [7:0]             tx_shift_q, tx_shift_d;
    logic                   tx_par_q, tx_par_d, tx_q, tx_d;
    // RX engine
    uart_state_t            rx_state_q, rx_state_d;
    logic [3:0]             rx_tick_q, rx_tick_d;
    logic [2:0]             rx_bit_q, rx_bit_d;
    logic [7:0]             rx_shift_q, rx_shift_d;

    logic          tick, rx_s, tx_pop, rx_push, rx_pop, tx_push;
    logic          par_set, frm_set, ovf_set;
    logic          apb_setup, apb_wr, apb_rd;
    logic [2:0]    reg_sel, err_clr;
    logic [7:0]    tx_head, rx_head;
    logic [c_AW:0] tx_count, rx_count;
    logic          tx_empty, tx_full, rx_empty, rx_full, rx_lvl_hit;
    logic [15:0]   status, rd_mux;
    logic          unused_ok;

    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign PRDATA    = prdata_q;
    assign TX        = tx_q;
    assign unused_ok = ^{PADDR[1:0], PWDATA};

    assign reg_sel   = PADDR[4:2];
    assign apb_setup = PSEL & ~PENABLE & ~PWRITE;
    assign apb_wr    = PSEL & PENABLE & PWRITE;
    assign apb_rd    = PSEL & PENABLE & ~PWRITE;
    assign tx_push   = apb_wr && (reg_sel == 3'd0);
    assign rx_pop    = apb_rd && (reg_sel == 3'd1);
    assign rx_s      = rx_sync_q[SYNC_STAGES-1];
    assign tick      = (baud_cnt_q == '0);

    apb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .AW(c_AW)) u_tx_fifo (
        .PCLK(PCLK), .PRESETN(PRESETN), .i_push(tx_push), .i_data(PWDATA[7:0]),
        .i_pop(tx_pop), .o_data(tx_head), .o_count(tx_count),
        .o_empty(tx_empty), .o_full(tx_full)
    );

    apb_uart_fifo_buf #(.DEPTH(FIFO_DEPTH), .AW(c_AW)) u_rx_fifo (
        .PCLK(PCLK), .PRESETN(PRESETN), .i_push(rx_push), .i_data(rx_shift_q),
        .i_pop(rx_pop), .o_data(rx_head), .o_count(rx_count),
        .o_empty(rx_empty), .o_full(rx_full)
    );

    assign rx_lvl_hit = (rx_count >= rxthr_q) && (rx_count != '0);
    assign IRQ        = |(ier_q & {|err_q, tx_empty, rx_lvl_hit});
    assign status     = {8'h00, (tx_state_q != S_IDLE), err_q, rx_full, ~rx_empty,
                         tx_full, tx_empty};

    // Register file, read mux and sticky flags
    always_comb begin
        baud_d     = baud_q;
        ctrl_d     = ctrl_q;
        ier_d      = ier_q;
        rxthr_d    = rxthr_q;
        err_clr    = 3'b000;
        // Divisor changes are only picked up at the next expiry.
        baud_cnt_d = tick ? baud_q : baud_cnt_q - 1'b1;
        rx_sync_d  = {rx_sync_q[SYNC_STAGES-2:0], RX};
        if (apb_wr) begin
            case (reg_sel)
                3'd2:    baud_d  = PWDATA[BAUD_W-1:0];
                3'd3:    ctrl_d  = PWDATA[3:0];
                3'd4:    err_clr = PWDATA[6:4];
                3'd5:    ier_d   = PWDATA[2:0];
                3'd6:    rxthr_d = PWDATA[c_AW:0];
                default: ;
            endcase
        end
        case (reg_sel)
            3'd1:    rd_mux = rx_empty ? 16'h0000 : {8'h00, rx_head};
            3'd2:    rd_mux = 16'(baud_q);
            3'd3:    rd_mux = {12'h000, ctrl_q};
            3'd4:    rd_mux = status;
            3'd5:    rd_mux = {13'h0000, ier_q};
            3'd6:    rd_mux = 16'(rxthr_q);
            3'd7:    rd_mux = {8'(tx_count), 8'(rx_count)};
            default: rd_mux = 16'h0000;
        endcase
        prdata_d = apb_setup ? rd_mux : prdata_q;
        // A set in the same cycle as a clear wins.
        err_d    = (err_q & ~err_clr) | {frm_set, par_set, ovf_set};
    end

    // TX engine: leaves IDLE only on a tick so every bit spans exactly 16 ticks.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_pop     = 1'b0;
        if (tick && tx_state_q != S_IDLE)
            tx_tick_d = tx_tick_q + 1'b1;
        case (tx_state_q)
            S_IDLE: if (tick && ctrl_q[0] && !tx_empty) begin
                tx_state_d = S_START;
                tx_pop     = 1'b1;
                tx_shift_d = tx_head;
                tx_par_d   = ^tx_head ^ ctrl_q[3];
                tx_tick_d  = 4'd0;
                tx_bit_d   = 3'd0;
            end
            S_START: if (tick && tx_tick_q == 4'd15) tx_state_d = S_DATA;
            S_DATA: if (tick && tx_tick_q == 4'd15) begin
                tx_shift_d = {1'b0, tx_shift_q[7:1]};
                tx_bit_d   = tx_bit_q + 1'b1;
                if (tx_bit_q == 3'd7)
                    tx_state_d = ctrl_q[2] ? S_PARITY : S_STOP;
            end
            S_PARITY: if (tick && tx_tick_q == 4'd15) tx_state_d = S_STOP;
            S_STOP:   if (tick && tx_tick_q == 4'd15) tx_state_d = S_IDLE;
            default:  tx_state_d = S_IDLE;
        endcase
        // Line level follows the next state so TX is glitch-free and registered.
        case (tx_state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = tx_shift_d[0];
            S_PARITY: tx_d = tx_par_d;
            default:  tx_d = 1'b1;
        endcase
    end

    // RX engine: start bit re-checked at tick 8, later bits sampled 16 ticks apart.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        par_set    = 1'b0;
        frm_set    = 1'b0;
        if (tick && rx_state_q != S_IDLE)
            rx_tick_d = rx_tick_q + 1'b1;
        case (rx_state_q)
            S_IDLE: if (rx_prev_q && !rx_s) begin
                rx_state_d = S_START;
                rx_tick_d  = 4'd0;
                rx_bit_d   = 3'd0;
            end
            S_START: if (tick && rx_tick_q == 4'd7) begin
                rx_tick_d  = 4'd0;
                rx_state_d = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: if (tick && rx_tick_q == 4'd15) begin
                rx_shift_d = {rx_s, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 1'b1;
                if (rx_bit_q == 3'd7)
                    rx_state_d = ctrl_q[2] ? S_PARITY : S_STOP;
            end
            S_PARITY: if (tick && rx_tick_q == 4'd15) begin
                par_set    = rx_s ^ (^rx_shift_q) ^ ctrl_q[3];
                rx_state_d = S_STOP;
            end
            S_STOP: if (tick && rx_tick_q == 4'd15) begin
                rx_state_d = S_IDLE;
                rx_push    = rx_s;
                frm_set    = ~rx_s;
            end
            default: rx_state_d = S_IDLE;
        endcase
        if (!ctrl_q[1]) begin
            rx_state_d = S_IDLE;
            rx_push    = 1'b0;
            par_set    = 1'b0;
            frm_set    = 1'b0;
        end
        ovf_set = rx_push & rx_full & ~rx_pop;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            baud_q     <= '0;
            baud_cnt_q <= '0;
            ctrl_q     <= '0;
            ier_q      <= '0;
            rxthr_q    <= '0;
            err_q      <= '0;
            prdata_q   <= '0;
            rx_sync_q  <= '1;
            rx_prev_q  <= 1'b1;
            tx_state_q <= S_IDLE;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            rx_state_q <= S_IDLE;
            rx_tick_q  <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            baud_q     <= baud_d;
            baud_cnt_q <= baud_cnt_d;
            ctrl_q     <= ctrl_d;
            ier_q      <= ier_d;
            rxthr_q    <= rxthr_d;
            err_q      <= err_d;
            prdata_q   <= prdata_d;
            rx_sync_q  <= rx_sync_d;
            rx_prev_q  <= rx_s;
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_apb_uart_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_apb_uart_fifo
//  Purpose  : Directed self-checking bench for apb_uart_fifo (FIFO_DEPTH=4,
//             BAUD=3 so one serial bit is 64 PCLK).
//  Revision : 1.0  initial release
// ============================================================================
module tb_apb_uart_fifo;
    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic [4:0]  PADDR = '0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [15:0] PWDATA = '0;
    logic [15:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        RX = 1'b1;
    logic        TX, IRQ;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [4:0] A_TX = 5'h00, A_RX = 5'h04, A_BAUD = 5'h08, A_CTRL = 5'h0C,
                           A_STAT = 5'h10, A_IER = 5'h14, A_THR = 5'h18, A_LVL = 5'h1C;

    apb_uart_fifo #(.FIFO_DEPTH(4), .BAUD_W(13), .SYNC_STAGES(2)) dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PADDR(PADDR), .PSEL(PSEL),
        .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .RX(RX), .TX(TX), .IRQ(IRQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic apb_write(input logic [4:0] a, input logic [15:0] d);
        @(posedge PCLK); #1; PSEL = 1; PWRITE = 1; PENABLE = 0; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1; PENABLE = 1;
        @(posedge PCLK); #1; PSEL = 0; PENABLE = 0; PWRITE = 0;
    endtask

    task automatic apb_read(input logic [4:0] a, output logic [15:0] d);
        @(posedge PCLK); #1; PSEL = 1; PWRITE = 0; PENABLE = 0; PADDR = a;
        @(posedge PCLK); #1; PENABLE = 1; d = PRDATA;
        @(posedge PCLK); #1; PSEL = 0; PENABLE = 0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic par, input logic stop);
        @(posedge PCLK); #1; RX = 1'b0; repeat (64) @(posedge PCLK);
        for (int i = 0; i < 8; i++) begin
            #1; RX = d[i]; repeat (64) @(posedge PCLK);
        end
        if (use_par) begin
            #1; RX = par; repeat (64) @(posedge PCLK);
        end
        #1; RX = stop; repeat (64) @(posedge PCLK);
        #1; RX = 1'b1; repeat (16) @(posedge PCLK);
    endtask

    task automatic test_reset;
        logic [15:0] v;
        repeat (3) @(posedge PCLK); #1;
        n_total++; if (TX !== 1'b1) $display("FAIL rst_tx: got %b expected 1", TX); else n_pass++;
        n_total++; if (IRQ !== 1'b0) $display("FAIL rst_irq: got %b expected 0", IRQ); else n_pass++;
        n_total++; if (PRDATA !== 16'h0) $display("FAIL rst_prdata: got %h expected 0000", PRDATA); else n_pass++;
        n_total++; if (PREADY !== 1'b1 || PSLVERR !== 1'b0)
            $display("FAIL rst_ready_err: got %b%b expected 10", PREADY, PSLVERR); else n_pass++;
        PRESETN = 1'b1;
        apb_read(A_STAT, v);
        n_total++; if (v !== 16'h0001) $display("FAIL rst_status: got %h expected 0001", v); else n_pass++;
        apb_read(A_LVL, v);
        n_total++; if (v !== 16'h0000) $display("FAIL rst_level: got %h expected 0000", v); else n_pass++;
        apb_read(A_BAUD, v);
        n_total++; if (v !== 16'h0000) $display("FAIL rst_baud: got %h expected 0000", v); else n_pass++;
    endtask

    task automatic test_tx_frame;
        logic [15:0] v;
        logic [8:0]  exp9;
        int k, lo;
        exp9 = {1'b1, 8'hA5};
        apb_write(A_BAUD, 16'd3);
        apb_read(A_BAUD, v);
        n_total++; if (v !== 16'h0003) $display("FAIL baud_rb: got %h expected 0003", v); else n_pass++;
        apb_write(A_CTRL, 16'h0001);
        apb_write(A_TX, 16'h00A5);
        k = 0;
        while (TX !== 1'b0 && k < 200) begin @(posedge PCLK); #1; k++; end
        n_total++; if (k >= 200) $display("FAIL tx_start_timeout: got TX=%b expected 0", TX); else n_pass++;
        lo = 0;
        while (TX === 1'b0 && lo < 200) begin @(posedge PCLK); #1; lo++; end
        n_total++; if (lo != 64) $display("FAIL tx_start_len: got %0d expected 64", lo); else n_pass++;
        for (int b = 0; b < 9; b++) begin
            repeat (32) begin @(posedge PCLK); #1; end
            n_total++;
            if (TX !== exp9[b]) $display("FAIL tx_bit%0d: got %b expected %b", b, TX, exp9[b]);
            else n_pass++;
            repeat (32) begin @(posedge PCLK); #1; end
        end
        apb_read(A_STAT, v);
        n_total++; if (v !== 16'h0001) $display("FAIL tx_done_status: got %h expected 0001", v); else n_pass++;
    endtask

    task automatic test_tx_busy;
        logic [15:0] v;
        apb_write(A_TX, 16'h005A);
        repeat (10) @(posedge PCLK);
        apb_read(A_STAT, v);
        n_total++; if (v !== 16'h0081) $display("FAIL tx_busy_on: got %h expected 0081", v); else n_pass++;
        repeat (700) @(posedge PCLK);
        apb_read(A_STAT, v);
        n_total++; if (v !== 16'h0001) $display("FAIL tx_busy_off: got %h expected 0001", v); else n_pass++;
        apb_write(A_CTRL, 16'h0000);
    endtask

    task automatic test_rx_parity;
        logic [15:0] v;
        apb_write(A_CTRL, 16'h000F);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1);   // 0x3C has even ones, odd parity bit = 1
        apb_read(A_STAT, v);
        n_total++; if (v !== 16'h0005) $display("FAIL par_ok_status: got %h expected 0005", v); else n_pass++;
        apb_read(A_RX, v);
        n_total++; if (v !== 16'h003C) $display("FAIL par_ok_data: got %h expected 003c", v); else n_pass++;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
        apb_read(A_STAT, v);
        n_total++; if (v !== 16'h0025) $display("FAIL par_bad_status: got %h expected 0025", v); else n_pass++;
        apb_read(A_RX, v);
        n_total++; if (v !== 16'h003C) $display("FAIL par_bad_data: got %h expected 003c", v); else n_pass++;
        apb_write(A_STAT, 16'h0020);
        apb_read(A_STAT, v);
        n_total++; if (v !== 16'h0001) $display("FAIL par_clear: got %h expected 0001", v); else n_pass++;
    endtask

    task automatic test_overflow;
        logic [15:0] v;
        logic [7:0]  bytes [5];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        apb_write(A_CTRL, 16'h0002);
        for (int i = 0; i < 5; i++) send_frame(bytes[i], 1'b0, 1'b0, 1'b1);
        apb_read(A_STAT, v);
        n_total++; if (v !== 16'h001D) $display("FAIL ovf_status: got %h expected 001d", v); else n_pass++;
        apb_read(A_LVL, v);
        n_total++; if (v !== 16'h0004) $display("FAIL ovf_level: got %h expected 0004", v); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            apb_read(A_RX, v);
            n_total++;
            if (v !== {8'h00, bytes[i]}) $display("FAIL ovf_data%0d: got %h expected %h", i, v, bytes[i]);
            else n_pass++;
        end
        apb_read(A_RX, v);
        n_total++; if (v !== 16'h0000) $display("FAIL rx_empty_read: got %h expected 0000", v); else n_pass++;
        apb_write(A_STAT, 16'h0010);
        apb_read(A_STAT, v);
        n_total++; if (v !== 16'h0001) $display("FAIL ovf_clear: got %h expected 0001", v); else n_pass++;
    endtask

    task automatic test_frame_err;
        logic [15:0] v;
        send_frame(8'h81, 1'b0, 1'b0, 1'b0);
        apb_read(A_STAT, v);
        n_total++; if (v !== 16'h0041) $display("FAIL frm_status: got %h expected 0041", v); else n_pass++;
        apb_read(A_LVL, v);
        n_total++; if (v !== 16'h0000) $display("FAIL frm_level: got %h expected 0000", v); else n_pass++;
        apb_write(A_STAT, 16'h0040);
        apb_read(A_STAT, v);
        n_total++; if (v !== 16'h0001) $display("FAIL frm_clear: got %h expected 0001", v); else n_pass++;
    endtask

    task automatic test_irq;
        logic [15:0] v;
        apb_write(A_IER, 16'h0001);
        apb_write(A_THR, 16'h0002);
        n_total++; if (IRQ !== 1'b0) $display("FAIL irq_idle: got %b expected 0", IRQ); else n_pass++;
        send_frame(8'h01, 1'b0, 1'b0, 1'b1);
        n_total++; if (IRQ !== 1'b0) $display("FAIL irq_one_byte: got %b expected 0", IRQ); else n_pass++;
        send_frame(8'h02, 1'b0, 1'b0, 1'b1);
        n_total++; if (IRQ !== 1'b1) $display("FAIL irq_two_bytes: got %b expected 1", IRQ); else n_pass++;
        apb_read(A_RX, v);
        n_total++; if (v !== 16'h0001) $display("FAIL irq_read_data: got %h expected 0001", v); else n_pass++;
        n_total++; if (IRQ !== 1'b0) $display("FAIL irq_after_read: got %b expected 0", IRQ); else n_pass++;
        apb_read(A_RX, v);
        apb_write(A_IER, 16'h0002);
        n_total++; if (IRQ !== 1'b1) $display("FAIL irq_tx_empty: got %b expected 1", IRQ); else n_pass++;
        apb_write(A_IER, 16'h0000);
    endtask

    task automatic test_reset_mid;
        logic [15:0] v;
        int k;
        apb_write(A_CTRL, 16'h0003);
        apb_write(A_THR, 16'h0001);
        apb_write(A_IER, 16'h0001);
        send_frame(8'h77, 1'b0, 1'b0, 1'b1);
        n_total++; if (IRQ !== 1'b1) $display("FAIL mid_irq_pre: got %b expected 1", IRQ); else n_pass++;
        apb_write(A_TX, 16'h00A5);
        apb_write(A_TX, 16'h005A);
        k = 0;
        while (TX !== 1'b0 && k < 200) begin @(posedge PCLK); #1; k++; end
        n_total++; if (k >= 200) $display("FAIL mid_start_timeout: got TX=%b expected 0", TX); else n_pass++;
        repeat (20) @(posedge PCLK);
        #1; PRESETN = 1'b0; #1;
        n_total++; if (TX !== 1'b1) $display("FAIL mid_tx: got %b expected 1", TX); else n_pass++;
        n_total++; if (IRQ !== 1'b0) $display("FAIL mid_irq: got %b expected 0", IRQ); else n_pass++;
        @(posedge PCLK); #1; PRESETN = 1'b1;
        apb_read(A_LVL, v);
        n_total++; if (v !== 16'h0000) $display("FAIL mid_level: got %h expected 0000", v); else n_pass++;
        apb_read(A_CTRL, v);
        n_total++; if (v !== 16'h0000) $display("FAIL mid_ctrl: got %h expected 0000", v); else n_pass++;
        apb_write(A_BAUD, 16'd3);
        apb_write(A_CTRL, 16'h0002);
        @(posedge PCLK); #1; RX = 1'b0;
        repeat (2) @(posedge PCLK);
        #1; RX = 1'b1;
        repeat (200) @(posedge PCLK);
        apb_read(A_STAT, v);
        n_total++; if (v !== 16'h0001) $display("FAIL glitch_status: got %h expected 0001", v); else n_pass++;
        apb_read(A_LVL, v);
        n_total++; if (v !== 16'h0000) $display("FAIL glitch_level: got %h expected 0000", v); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_tx_frame;
        test_tx_busy;
        test_rx_parity;
        test_overflow;
        test_frame_err;
        test_irq;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
